// File: rtl/ir_nec_decoder_ctrl_if.sv
// rtl/ir_nec_decoder_ctrl_if.sv - IR edge-flag inputs and decoded NEC frame outputs
interface ir_nec_decoder_ctrl_if;
    logic        ir_pos_flag;
    logic        ir_neg_flag;
    logic [31:0] ir_data;
    logic        data_valid;
    logic        repeat_valid;
    logic [7:0]  repeat_cnt;
    logic        frame_err;
    logic        busy;

    modport master (
        output ir_pos_flag, ir_neg_flag,
        input  ir_data, data_valid, repeat_valid, repeat_cnt, frame_err, busy
    );

    modport slave (
        input  ir_pos_flag, ir_neg_flag,
        output ir_data, data_valid, repeat_valid, repeat_cnt, frame_err, busy
    );
endinterface

// File: rtl/ir_nec_decoder_ctrl.sv
// rtl/ir_nec_decoder_ctrl.sv - NEC IR frame decoder driven by IRDA_RXD edge flags
module ir_nec_decoder_ctrl #(
    parameter int unsigned LEAD_LOW_MIN  = 400000,
    parameter int unsigned LEAD_LOW_MAX  = 500000,
    parameter int unsigned LEAD_HIGH_MIN = 200000,
    parameter int unsigned LEAD_HIGH_MAX = 250000,
    parameter int unsigned RPT_HIGH_MIN  = 100000,
    parameter int unsigned RPT_HIGH_MAX  = 125000,
    parameter int unsigned BIT_LOW_MIN   = 20000,
    parameter int unsigned BIT_LOW_MAX   = 36000,
    parameter int unsigned ZERO_HIGH_MAX = 45000,
    parameter int unsigned ONE_HIGH_MIN  = 70000,
    parameter int unsigned ONE_HIGH_MAX  = 100000,
    parameter int unsigned TIMEOUT       = 600000,
    parameter bit          CHECK_CMD     = 1'b1
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    ir_nec_decoder_ctrl_if.slave ir_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_LOW,
        S_LEAD_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_STOP
    } state_t;

    localparam logic [19:0] C_LEAD_LOW_MIN  = 20'(LEAD_LOW_MIN);
    localparam logic [19:0] C_LEAD_LOW_MAX  = 20'(LEAD_LOW_MAX);
    localparam logic [19:0] C_LEAD_HIGH_MIN = 20'(LEAD_HIGH_MIN);
    localparam logic [19:0] C_LEAD_HIGH_MAX = 20'(LEAD_HIGH_MAX);
    localparam logic [19:0] C_RPT_HIGH_MIN  = 20'(RPT_HIGH_MIN);
    localparam logic [19:0] C_RPT_HIGH_MAX  = 20'(RPT_HIGH_MAX);
    localparam logic [19:0] C_BIT_LOW_MIN   = 20'(BIT_LOW_MIN);
    localparam logic [19:0] C_BIT_LOW_MAX   = 20'(BIT_LOW_MAX);
    localparam logic [19:0] C_ZERO_HIGH_MAX = 20'(ZERO_HIGH_MAX);
    localparam logic [19:0] C_ONE_HIGH_MIN  = 20'(ONE_HIGH_MIN);
    localparam logic [19:0] C_ONE_HIGH_MAX  = 20'(ONE_HIGH_MAX);
    localparam logic [19:0] C_TIMEOUT       = 20'(TIMEOUT);

    state_t      r_state,        w_state_nxt;
    logic [19:0] r_cnt,          w_cnt_nxt;
    logic [31:0] r_sreg,         w_sreg_nxt;
    logic [4:0]  r_bit_idx,      w_bit_idx_nxt;
    logic        r_is_rpt,       w_is_rpt_nxt;
    logic        r_has_frame,    w_has_frame_nxt;
    logic [31:0] r_ir_data,      w_ir_data_nxt;
    logic        r_data_valid,   w_data_valid_nxt;
    logic        r_repeat_valid, w_repeat_valid_nxt;
    logic [7:0]  r_repeat_cnt,   w_repeat_cnt_nxt;
    logic        r_frame_err,    w_frame_err_nxt;

    logic w_pos;
    logic w_neg;
    logic w_edge;
    logic w_want_pos;
    logic w_timeout;
    logic w_is_zero;
    logic w_is_one;
    logic w_check_ok;
    logic w_err;

    function automatic logic in_win(input logic [19:0] v, input logic [19:0] lo, input logic [19:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Simultaneous pos+neg is a glitch: neither flag counts as an edge.
    assign w_pos      = ir_bus.ir_pos_flag & ~ir_bus.ir_neg_flag;
    assign w_neg      = ir_bus.ir_neg_flag & ~ir_bus.ir_pos_flag;
    assign w_edge     = w_pos | w_neg;
    assign w_want_pos = (r_state == S_LEAD_LOW) || (r_state == S_BIT_LOW) || (r_state == S_STOP);
    // Fires one cycle early so frame_err coincides with cnt reaching TIMEOUT.
    assign w_timeout  = (r_state != S_IDLE) && (r_cnt == C_TIMEOUT - 20'd1);
    assign w_is_zero  = in_win(r_cnt, C_BIT_LOW_MIN, C_ZERO_HIGH_MAX);
    assign w_is_one   = in_win(r_cnt, C_ONE_HIGH_MIN, C_ONE_HIGH_MAX);
    assign w_check_ok = !CHECK_CMD || (r_sreg[31:24] == ~r_sreg[23:16]);

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = (r_cnt >= C_TIMEOUT) ? C_TIMEOUT : r_cnt + 20'd1;
        w_sreg_nxt         = r_sreg;
        w_bit_idx_nxt      = r_bit_idx;
        w_is_rpt_nxt       = r_is_rpt;
        w_has_frame_nxt    = r_has_frame;
        w_ir_data_nxt      = r_ir_data;
        w_data_valid_nxt   = 1'b0;
        w_repeat_valid_nxt = 1'b0;
        w_repeat_cnt_nxt   = r_repeat_cnt;
        w_frame_err_nxt    = 1'b0;
        w_err              = 1'b0;

        if (r_state == S_IDLE) begin
            if (w_neg) begin
                w_state_nxt  = S_LEAD_LOW;
                w_cnt_nxt    = 20'd0;
                w_is_rpt_nxt = 1'b0;
            end
        end else if (w_edge) begin
            w_cnt_nxt = 20'd0;
            if (w_pos != w_want_pos) begin
                w_err = 1'b1;
            end else begin
                case (r_state)
                    S_LEAD_LOW: begin
                        if (in_win(r_cnt, C_LEAD_LOW_MIN, C_LEAD_LOW_MAX)) w_state_nxt = S_LEAD_HIGH;
                        else                                               w_err       = 1'b1;
                    end
                    S_LEAD_HIGH: begin
                        if (in_win(r_cnt, C_LEAD_HIGH_MIN, C_LEAD_HIGH_MAX)) begin
                            w_state_nxt   = S_BIT_LOW;
                            w_bit_idx_nxt = 5'd0;
                        end else if (in_win(r_cnt, C_RPT_HIGH_MIN, C_RPT_HIGH_MAX)) begin
                            w_state_nxt  = S_STOP;
                            w_is_rpt_nxt = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    S_BIT_LOW: begin
                        if (in_win(r_cnt, C_BIT_LOW_MIN, C_BIT_LOW_MAX)) w_state_nxt = S_BIT_HIGH;
                        else                                             w_err       = 1'b1;
                    end
                    S_BIT_HIGH: begin
                        if (w_is_zero || w_is_one) begin
                            w_sreg_nxt = {w_is_one, r_sreg[31:1]};
                            if (r_bit_idx == 5'd31) begin
                                w_state_nxt = S_STOP;
                            end else begin
                                w_bit_idx_nxt = r_bit_idx + 5'd1;
                                w_state_nxt   = S_BIT_LOW;
                            end
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    S_STOP: begin
                        w_state_nxt = S_IDLE;
                        if (!in_win(r_cnt, C_BIT_LOW_MIN, C_BIT_LOW_MAX)) begin
                            w_err = 1'b1;
                        end else if (r_is_rpt) begin
                            if (r_has_frame) begin
                                w_repeat_valid_nxt = 1'b1;
                                if (r_repeat_cnt != 8'hFF) w_repeat_cnt_nxt = r_repeat_cnt + 8'd1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end else if (w_check_ok) begin
                            w_ir_data_nxt    = r_sreg;
                            w_data_valid_nxt = 1'b1;
                            w_repeat_cnt_nxt = 8'd0;
                            w_has_frame_nxt  = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    default: w_err = 1'b1;
                endcase
            end
        end else if (w_timeout) begin
            w_err = 1'b1;
        end

        if (w_err) begin
            w_state_nxt     = S_IDLE;
            w_frame_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 20'd0;
            r_sreg         <= 32'd0;
            r_bit_idx      <= 5'd0;
            r_is_rpt       <= 1'b0;
            r_has_frame    <= 1'b0;
            r_ir_data      <= 32'd0;
            r_data_valid   <= 1'b0;
            r_repeat_valid <= 1'b0;
            r_repeat_cnt   <= 8'd0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_sreg         <= w_sreg_nxt;
            r_bit_idx      <= w_bit_idx_nxt;
            r_is_rpt       <= w_is_rpt_nxt;
            r_has_frame    <= w_has_frame_nxt;
            r_ir_data      <= w_ir_data_nxt;
            r_data_valid   <= w_data_valid_nxt;
            r_repeat_valid <= w_repeat_valid_nxt;
            r_repeat_cnt   <= w_repeat_cnt_nxt;
            r_frame_err    <= w_frame_err_nxt;
        end
    end

    assign ir_bus.ir_data      = r_ir_data;
    assign ir_bus.data_valid   = r_data_valid;
    assign ir_bus.repeat_valid = r_repeat_valid;
    assign ir_bus.repeat_cnt   = r_repeat_cnt;
    assign ir_bus.frame_err    = r_frame_err;
    assign ir_bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_ir_nec_decoder_ctrl.sv
// tb/tb_ir_nec_decoder_ctrl.sv - scoreboard bench for the NEC decoder, two CHECK_CMD variants
module tb_ir_nec_decoder_ctrl;
    localparam int LLMIN = 400, LLMAX = 500, LHMIN = 200, LHMAX = 250;
    localparam int RPMIN = 100, RPMAX = 125, BLMIN = 20, BLMAX = 36;
    localparam int ZMAX = 45, OMIN = 70, OMAX = 100, TO = 600;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          rcnt;
        int          at;
    } ev_t;

    logic CLOCK_50 = 1'b0;
    logic rst_n    = 1'b0;
    logic pos_f    = 1'b0;
    logic neg_f    = 1'b0;
    int   cyc      = 0;
    int   last     = 0;
    int   checks   = 0;
    int   errors   = 0;

    ev_t         q0[$];
    ev_t         q1[$];
    logic [31:0] m_data[2];
    int          m_rcnt[2];
    bit          m_has[2];
    bit          m_chk[2];

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    ir_nec_decoder_ctrl_if bus0();
    ir_nec_decoder_ctrl_if bus1();
    assign bus0.ir_pos_flag = pos_f;
    assign bus0.ir_neg_flag = neg_f;
    assign bus1.ir_pos_flag = pos_f;
    assign bus1.ir_neg_flag = neg_f;

    ir_nec_decoder_ctrl #(
        .LEAD_LOW_MIN(LLMIN), .LEAD_LOW_MAX(LLMAX), .LEAD_HIGH_MIN(LHMIN), .LEAD_HIGH_MAX(LHMAX),
        .RPT_HIGH_MIN(RPMIN), .RPT_HIGH_MAX(RPMAX), .BIT_LOW_MIN(BLMIN), .BIT_LOW_MAX(BLMAX),
        .ZERO_HIGH_MAX(ZMAX), .ONE_HIGH_MIN(OMIN), .ONE_HIGH_MAX(OMAX), .TIMEOUT(TO), .CHECK_CMD(1'b1)
    ) dut1 (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .ir_bus(bus1));

    ir_nec_decoder_ctrl #(
        .LEAD_LOW_MIN(LLMIN), .LEAD_LOW_MAX(LLMAX), .LEAD_HIGH_MIN(LHMIN), .LEAD_HIGH_MAX(LHMAX),
        .RPT_HIGH_MIN(RPMIN), .RPT_HIGH_MAX(RPMAX), .BIT_LOW_MIN(BLMIN), .BIT_LOW_MAX(BLMAX),
        .ZERO_HIGH_MAX(ZMAX), .ONE_HIGH_MIN(OMIN), .ONE_HIGH_MAX(OMAX), .TIMEOUT(TO), .CHECK_CMD(1'b0)
    ) dut0 (.CLOCK_50(CLOCK_50), .rst_n(rst_n), .ir_bus(bus0));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected outcomes: kind 0 = data_valid, 1 = repeat_valid, 2 = frame_err.
    task automatic push(input int d, input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.data = m_data[d];
        e.rcnt = m_rcnt[d];
        e.at   = at;
        if (d == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic expect_frame(input logic [31:0] v, input int at);
        for (int d = 0; d < 2; d++) begin
            if (!m_chk[d] || (v[31:24] == ~v[23:16])) begin
                m_data[d] = v;
                m_rcnt[d] = 0;
                m_has[d]  = 1'b1;
                push(d, 0, at);
            end else begin
                push(d, 2, at);
            end
        end
    endtask

    task automatic expect_repeat(input int at);
        for (int d = 0; d < 2; d++) begin
            if (m_has[d]) begin
                if (m_rcnt[d] < 255) m_rcnt[d]++;
                push(d, 1, at);
            end else begin
                push(d, 2, at);
            end
        end
    endtask

    task automatic expect_err(input int at);
        push(0, 2, at);
        push(1, 2, at);
    endtask

    task automatic mon(input int d, input logic dv, input logic rv, input logic fe, input logic bsy,
                       input logic [31:0] dat, input logic [7:0] rc);
        ev_t   e;
        int    kind;
        string n;
        if (!(dv || rv || fe)) return;
        n    = $sformatf("dut%0d", d);
        kind = dv ? 0 : (rv ? 1 : 2);
        chk({n, " pulse count"}, int'(dv) + int'(rv) + int'(fe), 1);
        chk({n, " busy at outcome"}, bsy, 0);
        if ((d == 1 && q1.size() == 0) || (d == 0 && q0.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected outcome actual=%0d required=none at cycle %0d", n, kind, cyc);
            return;
        end
        e = (d == 1) ? q1.pop_front() : q0.pop_front();
        chk({n, " outcome kind"}, kind, e.kind);
        chk({n, " outcome cycle"}, cyc, e.at);
        chk({n, " ir_data"}, dat, e.data);
        chk({n, " repeat_cnt"}, rc, e.rcnt);
    endtask

    always @(negedge CLOCK_50) begin
        if (rst_n) begin
            mon(1, bus1.data_valid, bus1.repeat_valid, bus1.frame_err, bus1.busy, bus1.ir_data, bus1.repeat_cnt);
            mon(0, bus0.data_valid, bus0.repeat_valid, bus0.frame_err, bus0.busy, bus0.ir_data, bus0.repeat_cnt);
        end
    end

    function automatic int pick(input int lo, input int hi, input int mode);
        if (mode == 1) return lo;
        if (mode == 2) return hi;
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic [31:0] rand_frame(input bit good);
        logic [7:0] a, c, n;
        a = 8'($urandom);
        c = 8'($urandom);
        n = good ? ~c : 8'($urandom);
        return {n, c, ~a, a};
    endfunction

    task automatic edge_f(input bit pol);
        if (pol) pos_f = 1'b1;
        else     neg_f = 1'b1;
        @(posedge CLOCK_50);
        #1;
        pos_f = 1'b0;
        neg_f = 1'b0;
        last  = cyc;
    endtask

    task automatic hold(input int d);
        repeat (d) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic glitch();
        pos_f = 1'b1;
        neg_f = 1'b1;
        @(posedge CLOCK_50);
        #1;
        pos_f = 1'b0;
        neg_f = 1'b0;
    endtask

    task automatic mid_reset();
        #4;
        rst_n = 1'b0;
        #1;
        chk("async reset ir_data", bus1.ir_data, 0);
        chk("async reset repeat_cnt", bus1.repeat_cnt, 0);
        chk("async reset busy", bus1.busy, 0);
        chk("async reset pulses", {bus1.data_valid, bus1.repeat_valid, bus1.frame_err}, 0);
        for (int d = 0; d < 2; d++) begin
            m_data[d] = 32'd0;
            m_rcnt[d] = 0;
            m_has[d]  = 1'b0;
        end
        hold(3);
        rst_n = 1'b1;
        hold(2);
    endtask

    // sp: 0 none, 1 bad space at bit sb, 2 line held low after bit sb, 3 glitch in space sb, 4 reset in bit sb
    task automatic send_frame(input logic [31:0] v, input int mode, input int sp, input int sb);
        int s;
        edge_f(1'b0); hold(pick(LLMIN, LLMAX, mode));
        edge_f(1'b1); hold(pick(LHMIN, LHMAX, mode));
        edge_f(1'b0);
        for (int i = 0; i < 32; i++) begin
            if (sp == 4 && i == sb) begin
                hold(5);
                mid_reset();
                edge_f(1'b1);
                hold(50);
                return;
            end
            hold(pick(BLMIN, BLMAX, mode));
            edge_f(1'b1);
            s = v[i] ? pick(OMIN, OMAX, mode) : pick(BLMIN, ZMAX, mode);
            if (sp == 1 && i == sb) s = 60;
            if (sp == 3 && i == sb) begin
                hold(s / 2);
                glitch();
                hold(s - s / 2 - 1);
            end else begin
                hold(s);
            end
            edge_f(1'b0);
            if (sp == 1 && i == sb) begin
                expect_err(last);
                hold(30); edge_f(1'b1); hold(50);
                return;
            end
            if (sp == 2 && i == sb) begin
                expect_err(last + TO);
                hold(TO + 20); edge_f(1'b1); hold(50);
                return;
            end
        end
        hold(pick(BLMIN, BLMAX, mode));
        edge_f(1'b1);
        expect_frame(v, last);
        hold(40);
    endtask

    task automatic send_repeat();
        edge_f(1'b0); hold(pick(LLMIN, LLMAX, 0));
        edge_f(1'b1); hold(pick(RPMIN, RPMAX, 0));
        edge_f(1'b0); hold(pick(BLMIN, BLMAX, 0));
        edge_f(1'b1);
        expect_repeat(last);
        hold(40);
    endtask

    task automatic send_bad_leader(input int len);
        edge_f(1'b0); hold(len);
        edge_f(1'b1);
        expect_err(last);
        hold(40);
    endtask

    initial begin
        m_chk[0] = 1'b0;
        m_chk[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_data[d] = 32'd0;
            m_rcnt[d] = 0;
            m_has[d]  = 1'b0;
        end
        #25;
        chk("reset ir_data", bus1.ir_data, 0);
        chk("reset repeat_cnt", bus1.repeat_cnt, 0);
        chk("reset busy", bus1.busy, 0);
        chk("reset data_valid", bus1.data_valid, 0);
        chk("reset repeat_valid", bus1.repeat_valid, 0);
        chk("reset frame_err", bus1.frame_err, 0);
        @(posedge CLOCK_50); #1;
        rst_n = 1'b1;
        hold(5);

        send_repeat();
        send_frame(32'hBA45FF00, 0, 0, -1);
        chk("frame ir_data", bus1.ir_data, 32'hBA45FF00);
        for (int k = 0; k < 3; k++) send_repeat();
        chk("after repeats repeat_cnt", bus1.repeat_cnt, 3);
        chk("after repeats ir_data", bus1.ir_data, 32'hBA45FF00);

        send_frame(32'hBB45FF00, 0, 0, -1);
        chk("bad cmd ir_data kept", bus1.ir_data, 32'hBA45FF00);
        chk("no check ir_data", bus0.ir_data, 32'hBB45FF00);

        send_bad_leader(380);
        send_bad_leader(LLMIN - 1);
        send_bad_leader(LLMAX + 1);
        chk("bad leader busy", bus1.busy, 0);
        send_frame(rand_frame(1'b1), 0, 1, int'($urandom_range(31, 0)));
        chk("bad space busy", bus1.busy, 0);
        send_frame(rand_frame(1'b1), 0, 2, 12);

        send_frame(rand_frame(1'b1), 1, 0, -1);
        send_frame(rand_frame(1'b1), 2, 0, -1);
        send_frame(rand_frame(1'b1), 0, 3, int'($urandom_range(25, 5)));
        for (int k = 0; k < 3; k++) send_frame(rand_frame(1'($urandom)), 0, 0, -1);
        send_repeat();

        send_frame(rand_frame(1'b1), 0, 4, 20);
        send_repeat();
        hold(100);

        chk("dut1 leftover expected", q1.size(), 0);
        chk("dut0 leftover expected", q0.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_nec_decoder_ctrl.md
Name: ir_nec_decoder_ctrl

Overview:
Sequencing controller for the IR receive path. Consumes the single-cycle rising/falling edge flags from the IRDA_RXD edge detectors and measures the interval between accepted edges. Walks an NEC-protocol state machine (leader, 32 data bits, stop burst, repeat code) and publishes the decoded 32-bit frame, repeat events and framing errors to downstream logic such as the display and key handlers. IRDA_RXD is idle-high: a falling edge starts a carrier burst.

Parameters:
LEAD_LOW_MIN, 400000, min cycles of the 9 ms leader low
LEAD_LOW_MAX, 500000, max cycles of the leader low
LEAD_HIGH_MIN, 200000, min cycles of the 4.5 ms leader space
LEAD_HIGH_MAX, 250000, max cycles of the leader space
RPT_HIGH_MIN, 100000, min cycles of the 2.25 ms repeat space
RPT_HIGH_MAX, 125000, max cycles of the repeat space
BIT_LOW_MIN, 20000, min cycles of the 560 us bit/stop burst
BIT_LOW_MAX, 36000, max cycles of the bit/stop burst
ZERO_HIGH_MAX, 45000, space in [BIT_LOW_MIN, ZERO_HIGH_MAX] decodes as 0
ONE_HIGH_MIN, 70000, space in [ONE_HIGH_MIN, ONE_HIGH_MAX] decodes as 1
ONE_HIGH_MAX, 100000, upper limit for a 1 space
TIMEOUT, 600000, cycles without an accepted edge before a frame is aborted
CHECK_CMD, 1, 1 = require byte3 == ~byte2

Ports:
CLOCK_50  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
ir_pos_flag  in  1  one-cycle pulse on a rising IRDA_RXD edge
ir_neg_flag  in  1  one-cycle pulse on a falling IRDA_RXD edge
ir_data  out  32  last good frame, LSB-first order: [7:0] addr, [15:8] addr_n, [23:16] cmd, [31:24] cmd_n
data_valid  out  1  one-cycle pulse when ir_data updates
repeat_valid  out  1  one-cycle pulse on an accepted repeat code
repeat_cnt  out  8  repeats since the last good frame, saturates at 255
frame_err  out  1  one-cycle pulse on any framing, timing or check failure
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; ir_data=0, data_valid=0, repeat_valid=0, repeat_cnt=0, frame_err=0, busy=0. Internal shift register, bit index, interval counter, is_rpt and has_frame are all 0.
- Interval counter cnt, 20 bits: cleared on every accepted edge, increments otherwise, saturates at TIMEOUT.
- Edge handling:
  - pos and neg flags high in the same cycle: treat as a glitch, ignore both; cnt keeps counting.
  - Edge of the wrong polarity for the current state: frame_err, go to IDLE. This does not apply in IDLE, where a pos edge is ignored.
- States and transitions:
  - IDLE: on neg go to LEAD_LOW, cnt=0, is_rpt=0.
  - LEAD_LOW, waiting for pos: cnt in leader-low window goes to LEAD_HIGH; otherwise error.
  - LEAD_HIGH, waiting for neg:
    - cnt in leader-high window: go to BIT_LOW, bit index=0.
    - cnt in repeat window: go to STOP with is_rpt=1.
    - otherwise: error.
  - BIT_LOW, waiting for pos: cnt in bit-low window goes to BIT_HIGH; otherwise error.
  - BIT_HIGH, waiting for neg:
    - Classify the space as 0 or 1. Outside both windows: error.
    - Shift: sreg <= {bit, sreg[31:1]}.
    - Bit index 31 goes to STOP; otherwise increment the index and go to BIT_LOW.
  - STOP, waiting for pos: cnt must be in bit-low window, else error.
    - is_rpt=1 and has_frame=1: repeat_valid pulse, repeat_cnt += 1 (saturating); ir_data unchanged.
    - is_rpt=1 and has_frame=0: frame_err.
    - is_rpt=0 and check passes (or CHECK_CMD=0): ir_data<=sreg, data_valid pulse, repeat_cnt=0, has_frame=1.
    - is_rpt=0 and check fails: frame_err; ir_data unchanged.
    - Every STOP outcome returns to IDLE.
- Timeout: cnt reaching TIMEOUT in any non-IDLE state gives frame_err and IDLE.
- Window compares are inclusive at both ends.
- Latency:
  - data_valid, repeat_valid and frame_err assert in the cycle after the deciding edge flag is sampled.
  - ir_data updates in the same cycle as data_valid.
  - Only one pulse output is high in any cycle.
- Error path: an error never disturbs ir_data, has_frame or repeat_cnt. The falling edge that caused an error is not reused as a new leader; the machine waits in IDLE for the next neg.
- Reset mid-frame: immediate return to reset values, and has_frame is cleared.

Test Plan:
1. Full frame, addr 0x00, cmd 0x45 (ir_data 0xBA45FF00) with nominal timing -> one data_valid, ir_data=0xBA45FF00, repeat_cnt=0, busy falls the same cycle.
2. Repeat burst (9 ms low, 2.25 ms high, 560 us low) sent 3 times after test 1 -> three repeat_valid pulses, repeat_cnt=3, ir_data still 0xBA45FF00. The same repeat sent straight after reset -> frame_err only.
3. Frame with cmd_n corrupted (0xBB45FF00), CHECK_CMD=1 -> frame_err, no data_valid, ir_data unchanged. With CHECK_CMD=0 -> data_valid, ir_data=0xBB45FF00.
4. Leader low 380000 cycles; separately, bit space 60000 cycles -> frame_err, state IDLE, no outputs updated.
5. Stop after bit 12 with the line held low -> frame_err exactly TIMEOUT cycles after the last accepted edge. The next good frame decodes normally.
6. pos and neg pulsed in the same cycle mid-frame -> ignored, frame decodes correctly. rst_n asserted at bit 20 -> all outputs 0 asynchronously, has_frame cleared.
